seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 209 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked multi-cycle unsigned ALU (add/sub/mul/div/mod)
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready  : operand handshake carrying a, b (WIDTH) and op (3)
//   out_valid/out_ready: result handshake carrying result, overflow, sign, err
//   busy               : high whenever the unit is not idle
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             sign,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [2:0]         op_q, op_n;
  // MUL: full product. DIV/MOD: remainder in the upper half, quotient in the lower half.
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [CW-1:0]      cnt_m1;
  logic               in_ready_q;
  logic [WIDTH-1:0]   result_q, result_n;
  logic               ov_q, ov_n;
  logic               sign_q, sign_n;
  logic               err_q, err_n;

  // MSB-first shift-add: shift the partial product and add the multiplicand when the bit is set.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_i,
                                                  input logic [WIDTH-1:0]   mcand,
                                                  input logic               mbit);
    mul_step = (acc_i << 1) + (mbit ? {{WIDTH{1'b0}}, mcand} : {(2*WIDTH){1'b0}});
  endfunction

  // Restoring division step: bring down one dividend bit, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc_i,
                                                  input logic               dbit,
                                                  input logic [WIDTH-1:0]   divisor);
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem;
    logic             qbit;
    trial = {acc_i[2*WIDTH-1:WIDTH], dbit};
    qbit  = (trial >= {1'b0, divisor});
    rem   = qbit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
    div_step = {rem, (acc_i[WIDTH-1:0] << 1) | {{(WIDTH-1){1'b0}}, qbit}};
  endfunction

  assign cnt_m1    = cnt - 1'b1;
  assign in_ready  = in_ready_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign overflow  = ov_q;
  assign sign      = sign_q;
  assign err       = err_q;

  always_comb begin
    state_n  = state;
    a_n      = a_q;
    b_n      = b_q;
    op_n     = op_q;
    acc_n    = acc;
    cnt_n    = cnt;
    result_n = result_q;
    ov_n     = ov_q;
    sign_n   = sign_q;
    err_n    = err_q;

    case (state)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_n  = a;
          b_n  = b;
          op_n = op;
          case (op)
            OP_ADD: begin
              state_n            = DONE;
              {ov_n, result_n}   = {1'b0, a} + {1'b0, b};
              sign_n             = 1'b0;
              err_n              = 1'b0;
            end
            OP_SUB: begin
              state_n  = DONE;
              ov_n     = 1'b0;
              err_n    = 1'b0;
              if (a >= b) begin
                result_n = a - b;
                sign_n   = 1'b0;
              end else begin
                result_n = b - a;
                sign_n   = 1'b1;
              end
            end
            OP_MUL: begin
              // The accept edge already consumes the top bit, so WIDTH-1 edges remain.
              state_n = CALC;
              acc_n   = mul_step({(2*WIDTH){1'b0}}, a, b[WIDTH-1]);
              cnt_n   = CW'(WIDTH - 1);
            end
            OP_DIV, OP_MOD: begin
              if (b == '0) begin
                state_n  = DONE;
                result_n = '0;
                ov_n     = 1'b0;
                sign_n   = 1'b0;
                err_n    = 1'b1;
              end else begin
                state_n = CALC;
                acc_n   = div_step({(2*WIDTH){1'b0}}, a[WIDTH-1], b);
                cnt_n   = CW'(WIDTH - 1);
              end
            end
            default: begin
              state_n  = DONE;
              result_n = '0;
              ov_n     = 1'b0;
              sign_n   = 1'b0;
              err_n    = 1'b1;
            end
          endcase
        end
      end

      CALC: begin
        // cnt counts remaining bits; bit index cnt-1 is processed on this edge.
        cnt_n = cnt_m1;
        if (op_q == OP_MUL) begin
          acc_n = mul_step(acc, a_q, b_q[cnt_m1]);
        end else begin
          acc_n = div_step(acc, a_q[cnt_m1], b_q);
        end
        if (cnt == CW'(1)) begin
          state_n = DONE;
          sign_n  = 1'b0;
          err_n   = 1'b0;
          if (op_q == OP_MUL) begin
            result_n = acc_n[WIDTH-1:0];
            ov_n     = |acc_n[2*WIDTH-1:WIDTH];
          end else if (op_q == OP_MOD) begin
            result_n = acc_n[2*WIDTH-1:WIDTH];
            ov_n     = 1'b0;
          end else begin
            result_n = acc_n[WIDTH-1:0];
            ov_n     = 1'b0;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      acc        <= '0;
      cnt        <= '0;
      in_ready_q <= 1'b0;
      result_q   <= '0;
      ov_q       <= 1'b0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      a_q        <= a_n;
      b_q        <= b_n;
      op_q       <= op_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      in_ready_q <= (state_n == IDLE);
      result_q   <= result_n;
      ov_q       <= ov_n;
      sign_q     <= sign_n;
      err_q      <= err_n;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=8 and WIDTH=16)
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b, result;
  logic [2:0]  op;
  logic        overflow, sign, err, busy;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [2:0]  op16;
  logic        overflow16, sign16, err16, busy16;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .sign(sign), .err(err), .busy(busy)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16), .op(op16),
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .overflow(overflow16), .sign(sign16), .err(err16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic [2:0] top, input logic [7:0] er, input logic eov,
                      input logic esign, input logic eerr, input int elat, input bit rel);
    int lat;
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 8'hff; b = 8'hff; op = 3'd1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_result"}, result, er);
    chk({tag, "_overflow"}, overflow, eov);
    chk({tag, "_sign"}, sign, esign);
    chk({tag, "_err"}, err, eerr);
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_released"}, out_valid, 0);
      chk({tag, "_result_kept"}, result, er);
    end
  endtask

  initial begin
    int lat16;
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready16", in_ready16, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    run8("add_small",  8'd10,  8'd15,  3'd0, 8'd25,  1'b0, 1'b0, 1'b0, 1, 1'b1);
    run8("add_carry",  8'd250, 8'd10,  3'd0, 8'd4,   1'b1, 1'b0, 1'b0, 1, 1'b1);
    run8("sub_neg",    8'd90,  8'd100, 3'd1, 8'd10,  1'b0, 1'b1, 1'b0, 1, 1'b1);
    run8("sub_pos",    8'd15,  8'd5,   3'd1, 8'd10,  1'b0, 1'b0, 1'b0, 1, 1'b1);
    run8("mul_ovf",    8'd30,  8'd50,  3'd2, 8'd220, 1'b1, 1'b0, 1'b0, 8, 1'b1);
    run8("mul_small",  8'd2,   8'd3,   3'd2, 8'd6,   1'b0, 1'b0, 1'b0, 8, 1'b1);
    run8("div",        8'd120, 8'd7,   3'd3, 8'd17,  1'b0, 1'b0, 1'b0, 8, 1'b1);
    run8("mod",        8'd120, 8'd7,   3'd4, 8'd1,   1'b0, 1'b0, 1'b0, 8, 1'b1);
    run8("mod_exact",  8'd120, 8'd10,  3'd4, 8'd0,   1'b0, 1'b0, 1'b0, 8, 1'b1);
    run8("div_zero",   8'd5,   8'd0,   3'd3, 8'd0,   1'b0, 1'b0, 1'b1, 1, 1'b1);
    run8("div_255_1",  8'd255, 8'd1,   3'd3, 8'd255, 1'b0, 1'b0, 1'b0, 8, 1'b1);
    run8("illegal_op", 8'd3,   8'd4,   3'd6, 8'd0,   1'b0, 1'b0, 1'b1, 1, 1'b1);

    // Backpressure: result held, no new accepts while DONE.
    run8("bp_mul",     8'd12,  8'd11,  3'd2, 8'd132, 1'b0, 1'b0, 1'b0, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'd1; b = 8'd1; op = 3'd0;
      chk("bp_result", result, 132);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_result", result, 132);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a = 8'd255; b = 8'd255; op = 3'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_result_stable", result, 132);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_result", result, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_err", err, 0);
    chk("mrst_in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_rel_in_ready", in_ready, 1);
    run8("post_rst_add", 8'd1, 8'd2, 3'd0, 8'd3, 1'b0, 1'b0, 1'b0, 1, 1'b1);

    // WIDTH=16 multiply.
    @(negedge clk);
    chk("w16_in_ready", in_ready16, 1);
    a16 = 16'd300; b16 = 16'd200; op16 = 3'd2; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0; a16 = '1; b16 = '1;
    lat16 = 1;
    while (!out_valid16 && lat16 < 100) begin
      @(negedge clk);
      lat16++;
    end
    chk("w16_latency", lat16, 16);
    chk("w16_result", result16, 60000);
    chk("w16_overflow", overflow16, 0);
    chk("w16_err", err16, 0);
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready16 = 1'b0;
    chk("w16_released", out_valid16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
